io_sw_conditioner: RTL
======================

Name: io_sw_conditioner

Overview:
Input conditioner that sits directly upstream of the single-cycle core and drives its io_sw_i bus from raw board switches and keys. Each bit passes through a multi-flop synchronizer and a per-bit debounce counter, so the core's LSU always reads a clean, metastability-free, bounce-free vector. A one-cycle change strobe is also produced for future interrupt or poll logic.

Parameters:
NUM_SW, 32, number of raw inputs conditioned (1..32); sw_o bits above NUM_SW-1 tie to 0
SYNC_STAGES, 2, synchronizer depth (>=2)
DB_CYCLES, 50000, consecutive clk_i cycles an input must differ from its stable value before the change is accepted (>=1)

Ports:
clk_i  input  1  system clock, same clock as the core
rst_ni  input  1  asynchronous active-low reset
sw_raw_i  input  NUM_SW  raw asynchronous switch/key levels
db_en_i  input  1  1 = debounce active; 0 = bypass debounce (synchronizer still used)
edge_clr_i  input  1  clears sticky edge register (used only with IO_SW_EDGE_EN)
sw_o  output  32  debounced switch vector, connects to core io_sw_i
sw_change_o  output  1  one-cycle pulse when any bit of sw_o changes
edge_o  output  32  sticky rising-edge flags (used only with IO_SW_EDGE_EN)

Behaviour:
- Reset: clk_i/rst_ni are the only clock and reset. Reset is asynchronous and active-low. All synchronizer flops, stable bits, counters, sw_o, sw_change_o and edge_o clear to 0 immediately on rst_ni=0. Reset asserted mid-debounce discards any pending change.
- Synchronizer: SYNC_STAGES flops per bit. syn[i] is the last stage.
- Per-bit FSM, two states:
  - STABLE: syn[i]==stable[i]; counter held 0. On syn[i]!=stable[i], move to PENDING with counter=1.
  - PENDING: while syn[i]!=stable[i], the counter increments each cycle. When the counter equals DB_CYCLES, on that edge stable[i]<=syn[i], counter<=0, return to STABLE. If syn[i]==stable[i] at any cycle (bounce back), counter<=0 and return to STABLE with no output change.
  - DB_CYCLES=1: the change is accepted on the first cycle of difference.
- Counter width: $clog2(DB_CYCLES+1). The counter never wraps; the compare stops it at DB_CYCLES.
- Latency: raw edge to sw_o change = SYNC_STAGES + DB_CYCLES cycles, for a clean edge held long enough.
- Bypass (db_en_i=0):
  - stable[i]<=syn[i] every cycle; counters forced 0.
  - Latency = SYNC_STAGES + 1.
  - Toggling db_en_i 1->0 mid-PENDING commits the current syn value next cycle.
- Outputs:
  - sw_o = zero-extended stable vector, registered.
  - sw_change_o = registered OR of (stable_next ^ stable); it asserts in the same cycle sw_o shows the new value.
- Simultaneous bits: bits are fully independent. Several bits may commit in the same cycle, which produces a single sw_change_o pulse.
- No combinational path from any input to any output.

Optional Feature:
Macro IO_SW_EDGE_EN.
- Defined: edge_o[i] sets to 1 in the cycle sw_o[i] rises 0->1 and stays set until edge_clr_i=1. edge_clr_i clears all flags on the next edge. If a clear and a new rise coincide, the rise wins and the flag stays 1.
- Not defined: no edge logic is instantiated; edge_o ties to 32'h0 and edge_clr_i is ignored.

Test Plan:
Bench parameters: NUM_SW=8, SYNC_STAGES=2, DB_CYCLES=4.
1. Reset then clean edge: release rst_ni, raw=8'h00; at cycle 10 drive raw=8'h01 and hold -> sw_o=32'h1 and sw_change_o=1 exactly 6 cycles later (cycle 16); sw_change_o=0 at cycle 17.
2. Bounce rejection: raw bit2 toggles 1,0,1,0 every cycle, then settles at 1 -> sw_o[2] stays 0 during bouncing; rises 6 cycles after the final settle; exactly one sw_change_o pulse.
3. Bypass: db_en_i=0, raw=8'hA5 -> sw_o=32'hA5 after 3 cycles; 1-cycle glitch on bit0 appears on sw_o for exactly 1 cycle.
4. Async reset mid-debounce: raw=8'hFF, drive rst_ni low 3 cycles after the edge (between clocks) -> sw_o=0 immediately without a clock edge; after release with raw=8'hFF held, sw_o=32'hFF 6 cycles later.
5. Multi-bit and upper bits: raw 8'h00->8'h3C in one cycle -> sw_o=32'h0000003C, a single sw_change_o pulse, and sw_o[31:8] always 0.
6. With IO_SW_EDGE_EN: bit7 rises -> edge_o=32'h80 sticky. Pulse edge_clr_i -> 0. Coincident clear and bit1 rise -> edge_o=32'h02. Without macro: edge_o=0 throughout.

Source files
------------

// File: rtl/io_sw_conditioner_if.sv
// io_sw_conditioner_if: switch conditioner bus between board-side driver and conditioner
// master drives sw_raw_i, db_en_i, edge_clr_i and observes sw_o, sw_change_o, edge_o; slave is the conditioner
interface io_sw_conditioner_if #(
  parameter int NUM_SW = 32
);
  logic [NUM_SW-1:0] sw_raw_i;
  logic              db_en_i;
  logic              edge_clr_i;
  logic [31:0]       sw_o;
  logic              sw_change_o;
  logic [31:0]       edge_o;
  modport master (output sw_raw_i, db_en_i, edge_clr_i, input sw_o, sw_change_o, edge_o);
  modport slave (input sw_raw_i, db_en_i, edge_clr_i, output sw_o, sw_change_o, edge_o);
endinterface

// File: rtl/io_sw_conditioner.sv
// io_sw_conditioner: synchronizes and debounces raw switches/keys into a clean io_sw_i vector for the core
// Ports: clk_i, rst_ni (async active-low); bus (slave): sw_raw_i, db_en_i, edge_clr_i in; sw_o, sw_change_o, edge_o out
// Define IO_SW_EDGE_EN to build sticky rising-edge flags on edge_o; otherwise edge_o is 0 and edge_clr_i is ignored
module io_sw_conditioner #(
  parameter int NUM_SW      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 50000
) (
  input logic                clk_i,
  input logic                rst_ni,
  io_sw_conditioner_if.slave bus
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);
  typedef enum logic {STABLE, PENDING} db_state_e;
  logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SW-1:0] sync_d [SYNC_STAGES];
  logic [NUM_SW-1:0] stable_q, stable_d;
  logic [CW-1:0]     cnt_q [NUM_SW];
  logic [CW-1:0]     cnt_d [NUM_SW];
  logic [CW-1:0]     cnt_inc [NUM_SW];
  db_state_e         state_q [NUM_SW];
  db_state_e         state_d [NUM_SW];
  logic              sw_change_q, sw_change_d;
  logic [NUM_SW-1:0] syn;
  assign syn = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d[0] = bus.sw_raw_i;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end
  // count this cycle would reach; checking it (not the held count) gives SYNC_STAGES+DB_CYCLES latency
  always_comb
    for (int i = 0; i < NUM_SW; i++) cnt_inc[i] = (state_q[i] == PENDING ? cnt_q[i] : '0) + CW'(1);
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i]   = '0;
      state_d[i] = STABLE;
      if (!bus.db_en_i) stable_d[i] = syn[i];
      else if (syn[i] != stable_q[i]) begin
        if (cnt_inc[i] == DB_MAX) stable_d[i] = syn[i];
        else begin
          cnt_d[i]   = cnt_inc[i];
          state_d[i] = PENDING;
        end
      end
    end
    sw_change_d = |(stable_d ^ stable_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q      <= '{default: '0};
      stable_q    <= '0;
      cnt_q       <= '{default: '0};
      state_q     <= '{default: STABLE};
      sw_change_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      sw_change_q <= sw_change_d;
    end
  assign bus.sw_o        = 32'(stable_q);
  assign bus.sw_change_o = sw_change_q;
`ifdef IO_SW_EDGE_EN
  logic [31:0] edge_q, edge_d;
  // a rise in the same cycle as a clear survives the clear
  always_comb edge_d = (bus.edge_clr_i ? '0 : edge_q) | 32'(stable_d & ~stable_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) edge_q <= '0;
    else edge_q <= edge_d;
  assign bus.edge_o = edge_q;
`else
  logic unused_edge_clr;
  assign unused_edge_clr = bus.edge_clr_i;
  assign bus.edge_o      = '0;
`endif
endmodule
